csr_trap_unit: RTL
==================

# csr_trap_unit

Machine-mode CSR file and trap sequencer for the minuteCore pipeline, generalising the combinational CSR/exception decode into a clocked unit. It executes CSR instructions, records synchronous exceptions and parametrised external interrupts into the trap CSRs, and issues a PC redirect with a pipeline flush through a valid/ready handshake. It sits beside the execute stage. It is the single owner of mstatus, mie, mip, mtvec, mepc, mcause, mtval, mscratch and mcycle.

## Interface
- XLEN, 32: data width of CSRs and writeback data; 32 or 64.
- NUM_IRQ, 4: external interrupt lines, 1..16; line i maps to mip/mie bit 16+i.
- RESET_MTVEC, 0: reset value of mtvec.
- CAUSE_W, 4: width of the exception code input.
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  CSR or SYSTEM instruction presented.
- req_ready  output  1  unit accepts req this cycle.
- opcode  input  5  instr[6:2]; SYSTEM = 5'b11100.
- funct  input  3  instr[14:12].
- csr_addr  input  12  instr[31:20].
- rs1_addr  input  5  rs1 index, also zimm.
- rs1_data  input  XLEN  rs1 operand.
- rd_addr  input  5  destination register.
- pc  input  XLEN  PC of the presented instruction or faulting instruction.
- exception_valid  input  1  synchronous exception from the pipeline.
- exception  input  CAUSE_W  exception code.
- exception_tval  input  XLEN  value for mtval.
- irq  input  NUM_IRQ  asynchronous level interrupt lines.
- wr_addr  output  5  register-file write index.
- wr_data  output  XLEN  old CSR value.
- wr_enable  output  1  register-file write strobe, one cycle.
- redirect_valid  output  1  new PC and flush pending.
- redirect_ready  input  1  fetch accepted redirect.
- redirect_pc  output  XLEN  trap vector or mepc.

## Operation
- FSM states: IDLE, TRAP_WR, REDIRECT.
- In IDLE, req_ready = !exception_valid && !irq_pending. In every other state req_ready = 0.
- CSR op: funct 001/010/011 (RW/RS/RC) use rs1_data. Funct 101/110/111 use zero-extended rs1_addr. RS/RC with source index 0 do not write the CSR. RW with rd_addr 0 still writes the CSR.
- Unimplemented csr_addr, or funct 100, is treated as an exception with cause 2 (illegal instruction) and mtval = 0.
- funct 000: csr_addr 0x000 is ECALL (cause 11). 0x001 is EBREAK (cause 3). 0x302 is MRET: mstatus.MIE <= MPIE, MPIE <= 1, redirect to mepc, go to REDIRECT. Any other value is illegal.
- Trap entry, in TRAP_WR:
  - mepc <= pc with bit 0 cleared.
  - mcause <= {interrupt bit, code}.
  - mtval <= tval.
  - MPIE <= MIE, MIE <= 0.
- redirect_pc = mtvec base in direct mode (mtvec[1:0]=00). In vectored mode (01) it is base + 4*code for interrupts and base for exceptions.
- Interrupts: irq passes through a 2-flop synchroniser into mip[16+i]. irq_pending = MIE && |(mie & mip). The lowest set i wins and the interrupt code is 16+i. mip is read-only and writes to it are ignored.
- mtvec[1:0] values 1x are written as 00.
- mcycle is 64-bit and increments every cycle. With XLEN=32 it reads as mcycle (0xB00) and mcycleh (0xB80). A write replaces the written half that cycle, with no increment.
- Priority in IDLE: exception_valid > irq_pending > req_valid.
- Reset values:
  - All CSRs are 0, except mtvec = RESET_MTVEC.
  - All outputs are 0, except req_ready, which is 1 when no event is pending.
  - FSM returns to IDLE.

## Timing
- CSR read/write: request accepted at cycle N. wr_enable, wr_addr and wr_data are registered and valid at N+1 for exactly one cycle. The CSR updates at the N+1 edge. wr_enable stays 0 when rd_addr = 0.
- Trap:
  - Event at N (IDLE); TRAP_WR at N+1.
  - redirect_valid asserted from N+2 and held stable until redirect_ready.
  - Return to IDLE the cycle after the handshake.
- MRET: accepted at N; redirect_valid from N+1.
- irq rise to irq_pending: 2 clk edges of latency.
- redirect_valid = 1 and redirect_ready = 1 in the same cycle is the handshake. Back-to-back traps need 1 IDLE cycle minimum.
- Reset asserted mid-trap clears all state at once. No redirect is issued and mepc is not kept.

## Test plan
- CSRRW mscratch, rs1_data 0xDEADBEEF, rd 5 -> next cycle wr_enable=1, wr_addr=5, wr_data=0. A following CSRRS x0 read returns 0xDEADBEEF.
- ECALL at pc 0x100, mtvec 0x200 -> mcause 11, mepc 0x100, MIE 0. redirect_pc 0x200 appears 2 cycles after the ECALL and is held through 3 cycles of redirect_ready=0.
- mtvec 0x301 (vectored), MIE=1, mie bit 17 set, irq[1] raised -> after sync, mcause 0x80000011 and redirect_pc 0x344.
- exception_valid (cause 5) with req_valid and a pending irq in the same cycle -> req_ready 0, mcause 5. MRET afterwards -> redirect to mepc and MIE restored.
- CSR read of 0x7FF -> cause 2 trap with no wr_enable. CSRRS of 0x344 (mip) with rs1 nonzero -> mip unchanged.
- reset_n pulsed low during REDIRECT -> redirect_valid is 0 in the same cycle and all CSRs return to reset values. mcycle counts 0, 1, 2 after release.

Source files
------------

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap sequencer beside the execute stage.
// Latency: CSR result registered one cycle after accept; trap redirect two cycles after the event, MRET one.
// Backpressure: req_ready low while an event is pending or a trap is in flight; redirect held until redirect_ready.
// Ports: req_* = CSR/SYSTEM instruction in, wr_* = register-file writeback out,
//        exception_* / irq = trap sources, redirect_* = new PC + flush to fetch.
module csr_trap_unit #(
  parameter int              XLEN        = 32,
  parameter int              NUM_IRQ     = 4,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0,
  parameter int              CAUSE_W     = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [4:0]         opcode,
  input  logic [2:0]         funct,
  input  logic [11:0]        csr_addr,
  input  logic [4:0]         rs1_addr,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [4:0]         rd_addr,
  input  logic [XLEN-1:0]    pc,
  input  logic               exception_valid,
  input  logic [CAUSE_W-1:0] exception,
  input  logic [XLEN-1:0]    exception_tval,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [4:0]         wr_addr,
  output logic [XLEN-1:0]    wr_data,
  output logic               wr_enable,
  output logic               redirect_valid,
  input  logic               redirect_ready,
  output logic [XLEN-1:0]    redirect_pc
);

  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  typedef enum logic [1:0] {IDLE, TRAP_WR, REDIRECT} state_t;
  state_t state, state_next;

  // Architectural state
  logic               mstatus_mie, mstatus_mpie;
  logic [NUM_IRQ-1:0] mie_irq, irq_meta, mip_irq;
  logic [XLEN-1:0]    mtvec, mepc, mcause, mtval, mscratch;
  logic [63:0]        mcycle;

  // Trap captured in IDLE, committed to the CSRs in TRAP_WR
  logic [XLEN-1:0]    trap_cause, trap_tval, trap_epc;

  logic               irq_pending;
  logic [4:0]         irq_code;
  logic               csr_hit;
  logic [XLEN-1:0]    csr_rdata, csr_src, csr_wval, trap_target;
  logic               csr_wen, is_mret, is_ecall, is_ebreak, is_csr;
  logic [3:0]         req_cause;
  logic               take_exc, take_irq, take_req;

  // Lowest-numbered enabled and pending line wins.
  always_comb begin
    irq_code = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (mie_irq[i] && mip_irq[i]) irq_code = 5'(16 + i);
    end
  end
  assign irq_pending = mstatus_mie && |(mie_irq & mip_irq);

  always_comb begin
    csr_hit   = 1'b1;
    csr_rdata = '0;
    case (csr_addr)
      12'h300: begin
        csr_rdata[3] = mstatus_mie;
        csr_rdata[7] = mstatus_mpie;
      end
      12'h304: csr_rdata[16 +: NUM_IRQ] = mie_irq;
      12'h305: csr_rdata = mtvec;
      12'h340: csr_rdata = mscratch;
      12'h341: csr_rdata = mepc;
      12'h342: csr_rdata = mcause;
      12'h343: csr_rdata = mtval;
      12'h344: csr_rdata[16 +: NUM_IRQ] = mip_irq;
      12'hB00: csr_rdata = mcycle[XLEN-1:0];
      12'hB80: begin
        // The upper half only exists as a separate CSR on 32-bit cores.
        if (XLEN == 32) csr_rdata = XLEN'(mcycle[63:32]);
        else            csr_hit   = 1'b0;
      end
      default: csr_hit = 1'b0;
    endcase
  end

  // Immediate forms take the zero-extended rs1 index as the operand.
  assign csr_src = funct[2] ? XLEN'(rs1_addr) : rs1_data;

  always_comb begin
    case (funct[1:0])
      2'b01:   csr_wval = csr_src;
      2'b10:   csr_wval = csr_rdata | csr_src;
      2'b11:   csr_wval = csr_rdata & ~csr_src;
      default: csr_wval = csr_rdata;
    endcase
  end

  // Set/clear with a zero source are pure reads; RW always writes.
  assign csr_wen   = (funct[1:0] == 2'b01) || (rs1_addr != 5'd0);
  assign is_ecall  = (opcode == OP_SYSTEM) && (funct == 3'b000) && (csr_addr == 12'h000);
  assign is_ebreak = (opcode == OP_SYSTEM) && (funct == 3'b000) && (csr_addr == 12'h001);
  assign is_mret   = (opcode == OP_SYSTEM) && (funct == 3'b000) && (csr_addr == 12'h302);
  assign is_csr    = (opcode == OP_SYSTEM) && (funct[1:0] != 2'b00) && csr_hit;
  assign req_cause = is_ecall ? 4'd11 : (is_ebreak ? 4'd3 : 4'd2);

  // Vectored mode offsets interrupts only; shifting left by two drops the interrupt bit.
  always_comb begin
    trap_target = {mtvec[XLEN-1:2], 2'b00};
    if (mtvec[1:0] == 2'b01 && trap_cause[XLEN-1])
      trap_target = {mtvec[XLEN-1:2], 2'b00} + {trap_cause[XLEN-3:0], 2'b00};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next     = state;
    req_ready      = 1'b0;
    redirect_valid = 1'b0;
    take_exc       = 1'b0;
    take_irq       = 1'b0;
    take_req       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !exception_valid && !irq_pending;
        if (exception_valid) begin
          take_exc   = 1'b1;
          state_next = TRAP_WR;
        end else if (irq_pending) begin
          take_irq   = 1'b1;
          state_next = TRAP_WR;
        end else if (req_valid) begin
          take_req = 1'b1;
          if (is_mret)      state_next = REDIRECT;
          else if (!is_csr) state_next = TRAP_WR;
        end
      end
      TRAP_WR:  state_next = REDIRECT;
      REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ready) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_irq      <= '0;
      irq_meta     <= '0;
      mip_irq      <= '0;
      mtvec        <= RESET_MTVEC;
      mepc         <= '0;
      mcause       <= '0;
      mtval        <= '0;
      mscratch     <= '0;
      mcycle       <= '0;
      trap_cause   <= '0;
      trap_tval    <= '0;
      trap_epc     <= '0;
      wr_enable    <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      redirect_pc  <= '0;
    end else begin
      irq_meta  <= irq;
      mip_irq   <= irq_meta;
      mcycle    <= mcycle + 64'd1;
      wr_enable <= 1'b0;

      if (take_exc) begin
        trap_cause <= XLEN'(exception);
        trap_tval  <= exception_tval;
        trap_epc   <= pc;
      end
      if (take_irq) begin
        trap_cause <= {1'b1, (XLEN-1)'(irq_code)};
        trap_tval  <= '0;
        trap_epc   <= pc;
      end
      if (take_req) begin
        if (is_mret) begin
          mstatus_mie  <= mstatus_mpie;
          mstatus_mpie <= 1'b1;
          redirect_pc  <= mepc;
        end else if (is_csr) begin
          wr_enable <= (rd_addr != 5'd0);
          wr_addr   <= rd_addr;
          wr_data   <= csr_rdata;
          if (csr_wen) begin
            case (csr_addr)
              12'h300: begin
                mstatus_mie  <= csr_wval[3];
                mstatus_mpie <= csr_wval[7];
              end
              12'h304: mie_irq  <= csr_wval[16 +: NUM_IRQ];
              // Reserved modes 1x collapse to direct.
              12'h305: mtvec    <= {csr_wval[XLEN-1:2], 1'b0, csr_wval[1] ? 1'b0 : csr_wval[0]};
              12'h340: mscratch <= csr_wval;
              12'h341: mepc     <= csr_wval;
              12'h342: mcause   <= csr_wval;
              12'h343: mtval    <= csr_wval;
              // A write to either half suppresses that cycle's increment.
              12'hB00: mcycle   <= (XLEN == 32) ? {mcycle[63:32], csr_wval[31:0]} : 64'(csr_wval);
              12'hB80: mcycle   <= {csr_wval[31:0], mcycle[31:0]};
              default: ;  // mip is read-only
            endcase
          end
        end else begin
          trap_cause <= XLEN'(req_cause);
          trap_tval  <= '0;
          trap_epc   <= pc;
        end
      end

      if (state == TRAP_WR) begin
        mepc         <= {trap_epc[XLEN-1:1], 1'b0};
        mcause       <= trap_cause;
        mtval        <= trap_tval;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
        redirect_pc  <= trap_target;
      end
    end
  end

endmodule
